mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter between the instruction-fetch side (PC/IF) and the MEM stage of the 5-stage pipeline. It serializes both requesters onto one variable-latency word bus, gives data accesses priority with a starvation guard for fetch, and drives per-side stall requests into `ctrl`. A branch flush can squash an in-flight fetch result.

## Interface
- `ADDR_W`, 32, address width (byte address)
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive MEM grants allowed while IF waits (≥1)

- `clk` in 1 — clock
- `rst` in 1 — reset, synchronous, active-low
- `if_req` in 1 — fetch request, held until `if_done` or `flush`
- `if_addr` in ADDR_W — fetch address
- `if_rdata` out DATA_W — fetched word, valid with `if_done`
- `if_done` out 1 — one-cycle fetch completion pulse
- `flush` in 1 — one-cycle pulse, discards the current or pending fetch
- `mem_req` in 1 — data request, held until `mem_done`
- `mem_we` in 1 — 1 = write
- `mem_addr` in ADDR_W — data address
- `mem_wdata` in DATA_W — write data
- `mem_sel` in 4 — byte enables
- `mem_rdata` out DATA_W — read data, valid with `mem_done`
- `mem_done` out 1 — one-cycle data completion pulse
- `bus_req` out 1 — bus transaction active
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_sel` out 1/ADDR_W/DATA_W/4 — registered bus command
- `bus_ack` in 1 — slave completion, one cycle
- `bus_rdata` in DATA_W — read data, valid with `bus_ack`
- `stallreq_if` out 1 — `if_req & ~if_done`, combinational
- `stallreq_mem` out 1 — `mem_req & ~mem_done`, combinational

## Operation
- FSM states: IDLE, IF_BUSY, MEM_BUSY.
- In IDLE, arbitration runs at each edge:
  - If only `mem_req` is high: go to MEM_BUSY.
  - If only `if_req` is high and `flush` is low: go to IF_BUSY.
  - If both are high: go to MEM_BUSY, unless `streak == STARVE_MAX`, in which case go to IF_BUSY.
- On a grant, the bus command is latched:
  - IF grant: `bus_we=0`, `bus_sel=4'b1111`, `bus_addr=if_addr`.
  - MEM grant: the `mem_*` inputs are copied.
  - `bus_req` goes to 1 and the command stays stable until ack.
- `streak` counter, width `$clog2(STARVE_MAX+1)`:
  - Increments on a MEM grant while `if_req` is high.
  - Clears on an IF grant, or on a MEM grant while `if_req` is low.
  - Saturates at STARVE_MAX.
- In a BUSY state, when `bus_ack` is sampled high:
  - `bus_req` drops.
  - The matching `*_done` pulses for the following cycle.
  - `*_rdata` is registered from `bus_rdata`; it holds until the next completion on that side.
  - FSM returns to IDLE.
  - This gives at least one IDLE cycle between transactions.
- `flush`:
  - In IF_BUSY it sets a `drop` flag. The bus transaction still completes (never aborted), but `if_done` is suppressed and `if_rdata` is not updated. `drop` clears on ack.
  - In IDLE it blocks an IF grant that same edge.
  - In MEM_BUSY it has no effect.
- `mem_sel` and `mem_wdata` are passed through unchanged; a write returns `mem_rdata` = `bus_rdata` (don't-care).
- Requester changing address while its request is in flight is illegal; the latched address is used.

## Timing
- Reset (`rst`=0 at an edge): state IDLE. `bus_req`, `bus_we`, `if_done`, `mem_done`, `drop` and `streak` go to 0. `bus_addr`, `bus_wdata`, `bus_sel`, `if_rdata` and `mem_rdata` go to 0.
- Reset mid-transaction: the same edge forces IDLE and `bus_req=0`, no done pulse. A late `bus_ack` after reset is ignored in IDLE.
- Latency: request sampled at edge k → `bus_req` high after k. Ack sampled at edge k+n (n≥1) → `done` high during cycle k+n, one cycle. Minimum request-to-done is 2 cycles.
- Done pulse and `stallreq` deassertion occur in the same cycle; `ctrl` releases the stall for that cycle only.
- `bus_ack` in IDLE is ignored.
- Simultaneous `flush` and `bus_ack` in IF_BUSY: the fetch is dropped and there is no `if_done`.

## Test plan
- IF only, `if_addr=0x100`, `bus_ack` 3 cycles after `bus_req` with `bus_rdata=0x00500093` → `bus_addr=0x100`, `bus_sel=4'hF`, `if_done` one cycle with `if_rdata=0x00500093`, `stallreq_if` low only that cycle.
- `if_req` and `mem_req` (read 0x2000) rise together, ack=1 cycle → MEM served first (`mem_done`), then IDLE, then IF granted; `stallreq_if` high throughout until `if_done`.
- `mem_req` re-asserted immediately after each `mem_done` with IF pending, STARVE_MAX=4 → exactly 4 MEM transactions, then IF granted; `streak` back to 0.
- `flush` pulse 1 cycle after IF grant of 0x104, then `if_req` with 0x200 → no `if_done` for 0x104, next `bus_addr=0x200`, `if_done` with its data.
- MEM write `addr=0x3000`, `wdata=0xDEADBEEF`, `sel=4'b0011` → `bus_we=1`, `bus_sel=4'b0011`, `bus_wdata=0xDEADBEEF`, `mem_done` after ack.
- `rst`=0 for one edge during MEM_BUSY → `bus_req=0` next cycle, no `mem_done`, ack asserted afterwards is ignored, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data requester and word-bus signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_sel;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_sel;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              stallreq_if;
  logic              stallreq_mem;

  modport master (
    input  if_req, if_addr, flush, mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
           bus_ack, bus_rdata,
    output if_rdata, if_done, mem_rdata, mem_done, bus_req, bus_we, bus_addr,
           bus_wdata, bus_sel, stallreq_if, stallreq_mem
  );

  modport slave (
    output if_req, if_addr, flush, mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
           bus_ack, bus_rdata,
    input  if_rdata, if_done, mem_rdata, mem_done, bus_req, bus_we, bus_addr,
           bus_wdata, bus_sel, stallreq_if, stallreq_mem
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port arbiter between instruction fetch and the MEM stage
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master arb
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

  state_t        state;
  logic          drop;
  logic [SW-1:0] streak;
  logic          if_win;

  // Data wins contention unless fetch has already been passed over STARVE_MAX times.
  assign if_win = arb.if_req && !arb.flush && (!arb.mem_req || streak == STREAK_MAX);

  assign arb.stallreq_if  = arb.if_req & ~arb.if_done;
  assign arb.stallreq_mem = arb.mem_req & ~arb.mem_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      drop          <= 1'b0;
      streak        <= '0;
      arb.bus_req   <= 1'b0;
      arb.bus_we    <= 1'b0;
      arb.bus_addr  <= {ADDR_W{1'b0}};
      arb.bus_wdata <= {DATA_W{1'b0}};
      arb.bus_sel   <= 4'b0000;
      arb.if_done   <= 1'b0;
      arb.mem_done  <= 1'b0;
      arb.if_rdata  <= {DATA_W{1'b0}};
      arb.mem_rdata <= {DATA_W{1'b0}};
    end else begin
      arb.if_done  <= 1'b0;
      arb.mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (if_win) begin
            state        <= IF_BUSY;
            arb.bus_req  <= 1'b1;
            arb.bus_we   <= 1'b0;
            arb.bus_sel  <= 4'b1111;
            arb.bus_addr <= arb.if_addr;
            streak       <= '0;
          end else if (arb.mem_req) begin
            state         <= MEM_BUSY;
            arb.bus_req   <= 1'b1;
            arb.bus_we    <= arb.mem_we;
            arb.bus_sel   <= arb.mem_sel;
            arb.bus_addr  <= arb.mem_addr;
            arb.bus_wdata <= arb.mem_wdata;
            if (!arb.if_req)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 1'b1;
          end
        end
        IF_BUSY: begin
          if (arb.bus_ack) begin
            state       <= IDLE;
            arb.bus_req <= 1'b0;
            drop        <= 1'b0;
            // A flush coinciding with the ack squashes the result just like an earlier one.
            if (!drop && !arb.flush) begin
              arb.if_done  <= 1'b1;
              arb.if_rdata <= arb.bus_rdata;
            end
          end else if (arb.flush) begin
            drop <= 1'b1;
          end
        end
        MEM_BUSY: begin
          if (arb.bus_ack) begin
            state         <= IDLE;
            arb.bus_req   <= 1'b0;
            arb.mem_done  <= 1'b1;
            arb.mem_rdata <= arb.bus_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction model
module tb_mem_arbiter;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failed = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus_if)
  );

  always #5 clk = ~clk;

  // Reference: who owns the bus (0 none, 1 fetch, 2 data), how often data has
  // been preferred over a waiting fetch, and the command/results it implies.
  int          m_owner = 0;
  int          m_passed = 0;
  bit          m_drop = 1'b0;
  bit          m_we = 1'b0;
  bit          m_if_done = 1'b0;
  bit          m_mem_done = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_mem_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit fetch_first;
    if (!rst) begin
      m_owner = 0; m_passed = 0; m_drop = 0; m_we = 0; m_if_done = 0; m_mem_done = 0;
      m_addr = '0; m_wdata = '0; m_sel = '0; m_if_rdata = '0; m_mem_rdata = '0;
      return;
    end
    m_if_done  = 0;
    m_mem_done = 0;
    if (m_owner == 0) begin
      fetch_first = bus_if.if_req && !bus_if.flush &&
                    (!bus_if.mem_req || m_passed >= STARVE_MAX);
      if (fetch_first) begin
        m_owner = 1; m_we = 0; m_sel = 4'hF; m_addr = bus_if.if_addr; m_passed = 0;
      end else if (bus_if.mem_req) begin
        m_owner = 2; m_we = bus_if.mem_we; m_sel = bus_if.mem_sel;
        m_addr = bus_if.mem_addr; m_wdata = bus_if.mem_wdata;
        m_passed = bus_if.if_req ? ((m_passed < STARVE_MAX) ? m_passed + 1 : m_passed) : 0;
      end
    end else if (bus_if.bus_ack) begin
      if (m_owner == 1 && !m_drop && !bus_if.flush) begin
        m_if_done = 1; m_if_rdata = bus_if.bus_rdata;
      end
      if (m_owner == 2) begin
        m_mem_done = 1; m_mem_rdata = bus_if.bus_rdata;
      end
      m_owner = 0;
      m_drop  = 0;
    end else if (m_owner == 1 && bus_if.flush) begin
      m_drop = 1;
    end
  endtask

  task automatic check_all();
    chk("bus_req",   64'(bus_if.bus_req),   64'(m_owner != 0));
    chk("bus_we",    64'(bus_if.bus_we),    64'(m_we));
    chk("bus_addr",  64'(bus_if.bus_addr),  64'(m_addr));
    chk("bus_wdata", 64'(bus_if.bus_wdata), 64'(m_wdata));
    chk("bus_sel",   64'(bus_if.bus_sel),   64'(m_sel));
    chk("if_done",   64'(bus_if.if_done),   64'(m_if_done));
    chk("if_rdata",  64'(bus_if.if_rdata),  64'(m_if_rdata));
    chk("mem_done",  64'(bus_if.mem_done),  64'(m_mem_done));
    chk("mem_rdata", 64'(bus_if.mem_rdata), 64'(m_mem_rdata));
    chk("stall_if",  64'(bus_if.stallreq_if),  64'(bus_if.if_req & ~m_if_done));
    chk("stall_mem", 64'(bus_if.stallreq_mem), 64'(bus_if.mem_req & ~m_mem_done));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic new_mem_cmd();
    bus_if.mem_we    = 1'($urandom_range(0, 1));
    bus_if.mem_addr  = $urandom & 32'hFFFF_FFFC;
    bus_if.mem_wdata = $urandom;
    bus_if.mem_sel   = 4'($urandom);
  endtask

  initial begin
    int  mem_count;
    bit  got_if;
    bus_if.if_req = 0; bus_if.if_addr = '0; bus_if.flush = 0;
    bus_if.mem_req = 0; bus_if.mem_we = 0; bus_if.mem_addr = '0;
    bus_if.mem_wdata = '0; bus_if.mem_sel = '0;
    bus_if.bus_ack = 0; bus_if.bus_rdata = '0;

    // Reset state
    tick();
    tick();
    chk("rst_bus_req", 64'(bus_if.bus_req), 64'd0);
    rst = 1;
    tick();

    // Fetch only, ack three edges after grant
    bus_if.if_req = 1; bus_if.if_addr = 32'h100;
    tick();
    chk("t1_addr", 64'(bus_if.bus_addr), 64'h100);
    chk("t1_sel", 64'(bus_if.bus_sel), 64'hF);
    tick();
    tick();
    bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h0050_0093;
    tick();
    chk("t1_done", 64'(bus_if.if_done), 64'd1);
    chk("t1_rdata", 64'(bus_if.if_rdata), 64'h0050_0093);
    chk("t1_stall_rel", 64'(bus_if.stallreq_if), 64'd0);
    bus_if.bus_ack = 0; bus_if.if_req = 0;
    tick();
    chk("t1_done_pulse", 64'(bus_if.if_done), 64'd0);

    // Simultaneous requests: data first, then fetch
    bus_if.if_req = 1; bus_if.if_addr = 32'h104;
    bus_if.mem_req = 1; bus_if.mem_we = 0; bus_if.mem_addr = 32'h2000; bus_if.mem_sel = 4'hF;
    bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h1111_2222;
    tick();
    chk("t2_mem_first", 64'(bus_if.bus_addr), 64'h2000);
    tick();
    chk("t2_mem_done", 64'(bus_if.mem_done), 64'd1);
    chk("t2_stall_if", 64'(bus_if.stallreq_if), 64'd1);
    bus_if.mem_req = 0; bus_if.bus_rdata = 32'h3333_4444;
    tick();
    chk("t2_if_addr", 64'(bus_if.bus_addr), 64'h104);
    tick();
    chk("t2_if_done", 64'(bus_if.if_done), 64'd1);
    bus_if.if_req = 0; bus_if.bus_ack = 0;
    tick();

    // Starvation guard: data re-requests back to back while fetch waits
    bus_if.if_req = 1; bus_if.if_addr = 32'h108;
    bus_if.mem_req = 1; bus_if.mem_addr = 32'h2004; bus_if.mem_we = 0;
    bus_if.bus_ack = 1;
    mem_count = 0; got_if = 0;
    for (int i = 0; i < 40 && !got_if; i++) begin
      bus_if.bus_rdata = $urandom;
      tick();
      if (bus_if.mem_done) mem_count++;
      if (bus_if.if_done) got_if = 1;
    end
    bus_if.mem_req = 0; bus_if.if_req = 0; bus_if.bus_ack = 0;
    chk("t3_if_served", 64'(got_if), 64'd1);
    chk("t3_mem_count", 64'(mem_count), 64'(STARVE_MAX));
    tick();

    // Flush during fetch, then a new fetch
    bus_if.if_req = 1; bus_if.if_addr = 32'h104;
    tick();
    bus_if.flush = 1; bus_if.if_req = 0;
    tick();
    bus_if.flush = 0;
    tick();
    bus_if.bus_ack = 1; bus_if.bus_rdata = 32'hAAAA_5555;
    tick();
    chk("t4_dropped", 64'(bus_if.if_done), 64'd0);
    bus_if.bus_ack = 0;
    bus_if.if_req = 1; bus_if.if_addr = 32'h200;
    tick();
    chk("t4_new_addr", 64'(bus_if.bus_addr), 64'h200);
    bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h1234_5678;
    tick();
    chk("t4_done", 64'(bus_if.if_done), 64'd1);
    chk("t4_rdata", 64'(bus_if.if_rdata), 64'h1234_5678);
    bus_if.if_req = 0; bus_if.bus_ack = 0;
    tick();

    // Data write pass-through
    bus_if.mem_req = 1; bus_if.mem_we = 1; bus_if.mem_addr = 32'h3000;
    bus_if.mem_wdata = 32'hDEAD_BEEF; bus_if.mem_sel = 4'b0011;
    tick();
    chk("t5_we", 64'(bus_if.bus_we), 64'd1);
    chk("t5_sel", 64'(bus_if.bus_sel), 64'h3);
    chk("t5_wdata", 64'(bus_if.bus_wdata), 64'hDEAD_BEEF);
    bus_if.bus_ack = 1; bus_if.bus_rdata = $urandom;
    tick();
    chk("t5_done", 64'(bus_if.mem_done), 64'd1);
    bus_if.mem_req = 0; bus_if.bus_ack = 0;
    tick();

    // Reset in the middle of a data read
    bus_if.mem_req = 1; bus_if.mem_we = 0; bus_if.mem_addr = 32'h4000; bus_if.mem_sel = 4'hF;
    tick();
    rst = 0;
    tick();
    chk("t6_bus_req", 64'(bus_if.bus_req), 64'd0);
    rst = 1; bus_if.mem_req = 0; bus_if.bus_ack = 1;
    tick();
    chk("t6_no_done", 64'(bus_if.mem_done), 64'd0);
    bus_if.bus_ack = 0;
    tick();
    chk("t6_addr_zero", 64'(bus_if.bus_addr), 64'd0);
    chk("t6_rdata_zero", 64'(bus_if.mem_rdata), 64'd0);

    // Random traffic on both sides with a randomly-timed slave
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      bus_if.flush = 0;
      if (m_if_done) begin
        bus_if.if_req = 1'($urandom_range(0, 1));
        bus_if.if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (bus_if.if_req && $urandom_range(0, 11) == 0) begin
        bus_if.flush = 1; bus_if.if_req = 0;
      end else if (!bus_if.if_req && $urandom_range(0, 2) == 0) begin
        bus_if.if_req = 1; bus_if.if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (m_mem_done) begin
        bus_if.mem_req = 1'($urandom_range(0, 1));
        new_mem_cmd();
      end else if (!bus_if.mem_req && $urandom_range(0, 2) == 0) begin
        bus_if.mem_req = 1;
        new_mem_cmd();
      end
      bus_if.bus_ack = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      bus_if.bus_rdata = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
